// File: rtl/ram_dump_tx.sv
// Dumps a block of 32-bit RAM words over an 8N1 UART: "TEKNOFEST" header,
// a 4-byte MSB-first word count, then each word MSB first.
module ram_dump_tx #(
    parameter int CPU_CLK    = 125_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [31:0]           word_count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [31:0]           rd_data_i,
    output logic                  tx_o
);

    localparam int DIV = CPU_CLK / BAUD_RATE;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE, HEADER, LENGTH, READ, WAIT_DATA, SEND_WORD, DONE
    } state_t;

    state_t                state_q;
    logic [BW-1:0]         baud_q;
    logic [3:0]            bit_q;   // 0 start, 1..8 data, 9 stop
    logic [3:0]            byte_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           count_q;
    logic [31:0]           sent_q;
    logic [31:0]           word_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    logic [7:0]            cur_byte;
    logic                  baud_end;
    logic                  last_byte;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [31:0]           sent_d;

    function automatic logic [7:0] header_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h54;
            4'd1:    return 8'h45;
            4'd2:    return 8'h4B;
            4'd3:    return 8'h4E;
            4'd4:    return 8'h4F;
            4'd5:    return 8'h46;
            4'd6:    return 8'h45;
            4'd7:    return 8'h53;
            default: return 8'h54;
        endcase
    endfunction

    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            HEADER: cur_byte = header_byte(byte_q);
            LENGTH: begin
                case (byte_q[1:0])
                    2'd0:    cur_byte = count_q[31:24];
                    2'd1:    cur_byte = count_q[23:16];
                    2'd2:    cur_byte = count_q[15:8];
                    default: cur_byte = count_q[7:0];
                endcase
            end
            SEND_WORD: cur_byte = word_q[31:24];
            default:   cur_byte = 8'h00;
        endcase
    end

    assign baud_end  = (baud_q == BAUD_LAST);
    assign last_byte = (state_q == HEADER) ? (byte_q == 4'd8) : (byte_q == 4'd3);
    assign addr_d    = addr_q + ADDR_WIDTH'(1);
    assign sent_d    = sent_q + 32'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= 4'd0;
            byte_q    <= 4'd0;
            addr_q    <= '0;
            count_q   <= 32'd0;
            sent_q    <= 32'd0;
            word_q    <= 32'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (start_i) begin
                        addr_q  <= base_addr_i;
                        count_q <= word_count_i;
                        sent_q  <= 32'd0;
                        byte_q  <= 4'd0;
                        bit_q   <= 4'd0;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= HEADER;
                    end
                end
                HEADER, LENGTH, SEND_WORD: begin
                    if (!baud_end) begin
                        baud_q <= baud_q + BW'(1);
                    end else if (bit_q != 4'd9) begin
                        baud_q <= '0;
                        bit_q  <= bit_q + 4'd1;
                        tx_q   <= (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
                    end else begin
                        // Stop bit finished: next start bit goes out on this same edge.
                        baud_q <= '0;
                        bit_q  <= 4'd0;
                        byte_q <= byte_q + 4'd1;
                        tx_q   <= 1'b0;
                        if (state_q == SEND_WORD) begin
                            word_q <= {word_q[23:0], 8'h00};
                        end
                        if (last_byte) begin
                            byte_q <= 4'd0;
                            if (state_q == HEADER) begin
                                state_q <= LENGTH;
                            end else begin
                                if (state_q == SEND_WORD) begin
                                    addr_q <= addr_d;
                                    sent_q <= sent_d;
                                end
                                if ((state_q == LENGTH && count_q != 32'd0) ||
                                    (state_q == SEND_WORD && sent_d != count_q)) begin
                                    tx_q      <= 1'b1;
                                    rd_en_q   <= 1'b1;
                                    rd_addr_q <= (state_q == LENGTH) ? addr_q : addr_d;
                                    state_q   <= READ;
                                end else begin
                                    tx_q    <= 1'b1;
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= DONE;
                                end
                            end
                        end
                    end
                end
                READ: begin
                    state_q <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    word_q  <= rd_data_i;
                    tx_q    <= 1'b0;
                    state_q <= SEND_WORD;
                end
                DONE: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign tx_o      = tx_q;

endmodule

// File: tb/tb_ram_dump_tx.sv
// Bench for ram_dump_tx: a UART decoder checks every transmitted byte against
// a byte/address queue built from the dump rules; a second instance checks real baud timing.
module tb_ram_dump_tx;

    localparam int AW  = 17;
    localparam int DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, busy, done, rd_en, tx;
    logic [AW-1:0] base, rd_addr;
    logic [31:0]   wcount, rd_data;

    logic          rst2, start2, busy2, done2, rd_en2, tx2;
    logic [AW-1:0] base2, rd_addr2;
    logic [31:0]   wcount2;
    logic [31:0]   rd_data2 = 32'd0;

    ram_dump_tx #(.CPU_CLK(460800), .BAUD_RATE(115200), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base),
        .word_count_i(wcount), .busy_o(busy), .done_o(done), .rd_en_o(rd_en),
        .rd_addr_o(rd_addr), .rd_data_i(rd_data), .tx_o(tx)
    );

    ram_dump_tx dut2 (
        .clk_i(clk), .rst_i(rst2), .start_i(start2), .base_addr_i(base2),
        .word_count_i(wcount2), .busy_o(busy2), .done_o(done2), .rd_en_o(rd_en2),
        .rd_addr_o(rd_addr2), .rd_data_i(rd_data2), .tx_o(tx2)
    );

    // RAM contents are a fixed function of the address.
    function automatic logic [31:0] ram_val(input logic [AW-1:0] a);
        if (a == 17'h00010) return 32'hDEADBEEF;
        if (a == 17'h00011) return 32'h01020304;
        return ({15'b0, a} * 32'h9E3779B1) ^ 32'h5A5A0FF0;
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= ram_val(rd_addr);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    logic [7:0] hdr [9] = '{8'h54, 8'h45, 8'h4B, 8'h4E, 8'h4F, 8'h46, 8'h45, 8'h53, 8'h54};
    logic [7:0] lit34 [21] = '{8'h54, 8'h45, 8'h4B, 8'h4E, 8'h4F, 8'h46, 8'h45, 8'h53, 8'h54,
                               8'h00, 8'h00, 8'h00, 8'h02,
                               8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};

    // Model state: expected bytes (with "must follow previous byte directly" flag) and reads.
    logic [7:0]    exp_q[$];
    bit            follow_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    got_q[$];
    logic [AW-1:0] addr_log[$];
    bit            run_active = 1'b0;
    int            run_bytes  = 0;

    task automatic push_model(input logic [AW-1:0] b, input logic [31:0] n);
        logic [AW-1:0] a;
        logic [31:0]   d;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(hdr[i]);
            follow_q.push_back(i != 0);
        end
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back(n[8*i +: 8]);
            follow_q.push_back(1'b1);
        end
        for (int w = 0; w < int'(n); w++) begin
            a = b + AW'(w);
            exp_addr_q.push_back(a);
            d = ram_val(a);
            for (int i = 3; i >= 0; i--) begin
                exp_q.push_back(d[8*i +: 8]);
                follow_q.push_back(i != 3);
            end
        end
    endtask

    // Compare process: decodes tx, checks read port, busy and done every cycle.
    int            cyc = 0;
    bit            rx_on = 1'b0, rx_orphan = 1'b0, rx_follow = 1'b0;
    int            rx_cnt = 0, rx_err = 0, last_end_cyc = 0, frame_first = 0, frame_last = 0;
    logic [7:0]    rx_byte, rx_exp;
    bit            expect_done = 1'b0, chk_reset = 1'b0;
    logic          prev_rd_en = 1'b0;
    logic [AW-1:0] last_addr = '0;

    always @(negedge clk) begin
        int   bi;
        logic lvl;
        cyc++;
        if (rst) begin
            rx_on = 1'b0;
            exp_q.delete();
            follow_q.delete();
            exp_addr_q.delete();
            run_active  = 1'b0;
            expect_done = 1'b0;
            chk_reset   = 1'b1;
            prev_rd_en  = 1'b0;
            last_addr   = '0;
        end else begin
            if (chk_reset) begin
                chk_reset = 1'b0;
                check("rst_tx", tx, 1);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_rd_en", rd_en, 0);
                check("rst_rd_addr", rd_addr, 0);
            end
            if (rd_en === 1'b1) begin
                check("rd_single_pulse", prev_rd_en, 0);
                if (exp_addr_q.size() == 0) fail_now("rd_extra", $sformatf("read at %0h, none expected", rd_addr));
                else begin
                    check("rd_addr", rd_addr, exp_addr_q.pop_front());
                    addr_log.push_back(rd_addr);
                end
            end else begin
                check("rd_addr_hold", rd_addr, last_addr);
            end
            last_addr  = rd_addr;
            prev_rd_en = rd_en;

            if (expect_done) begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                check("reads_left", exp_addr_q.size(), 0);
                expect_done = 1'b0;
                run_active  = 1'b0;
            end else begin
                check("done_quiet", done, 0);
                check("busy", busy, run_active);
            end

            if (!rx_on) begin
                if (tx === 1'b0) begin
                    rx_on = 1'b1; rx_cnt = 0; rx_err = 0; rx_byte = 8'h00;
                    if (exp_q.size() == 0) begin
                        fail_now("tx_extra", "start bit with no byte expected");
                        rx_orphan = 1'b1; rx_exp = 8'h00;
                    end else begin
                        rx_orphan = 1'b0;
                        rx_exp    = exp_q.pop_front();
                        rx_follow = follow_q.pop_front();
                        if (rx_follow) check("back_to_back", cyc - last_end_cyc, 1);
                        if (run_bytes == 0) frame_first = cyc;
                    end
                end else begin
                    check("tx_idle", tx, 1);
                end
            end
            if (rx_on) begin
                bi  = rx_cnt / DIV;
                lvl = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : rx_exp[bi-1];
                if (tx !== lvl) rx_err++;
                if ((rx_cnt % DIV) == DIV / 2 && bi >= 1 && bi <= 8) rx_byte[bi-1] = tx;
                if (rx_cnt == 10 * DIV - 1) begin
                    rx_on = 1'b0;
                    last_end_cyc = cyc;
                    if (!rx_orphan) begin
                        check("byte", rx_byte, rx_exp);
                        check("bit_levels", rx_err, 0);
                        got_q.push_back(rx_byte);
                        run_bytes++;
                        frame_last = cyc;
                        if (exp_q.size() == 0 && run_active) expect_done = 1'b1;
                    end
                end else begin
                    rx_cnt++;
                end
            end
        end
    end

    task automatic do_reset(input bit with_start);
        @(posedge clk); #1;
        rst = 1'b1; start = with_start; base = AW'($urandom); wcount = 32'd3;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic run_dump(input logic [AW-1:0] b, input logic [31:0] n);
        @(posedge clk); #1;
        start = 1'b1; base = b; wcount = n;
        @(posedge clk); #1;
        start = 1'b0; base = AW'($urandom); wcount = $urandom;
        got_q.delete();
        addr_log.delete();
        run_bytes = 0;
        push_model(b, n);
        run_active = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (run_active && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (run_active) begin
            fail_now("timeout", "dump did not finish within budget");
            do_reset(1'b0);
        end
        @(posedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int runs [8];
        int exp_runs [8] = '{3255, 1085, 1085, 1085, 1085, 1085, 1085, 1085};
        int n;
        logic lv;

        rst = 1'b1; start = 1'b0; base = '0; wcount = 32'd0;
        rst2 = 1'b1; start2 = 1'b0; base2 = '0; wcount2 = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // Empty dump: header plus zero length, 13 bytes in 13*10*DIV cycles.
        run_dump(17'h00010, 32'd0);
        wait_idle(2000);
        check("cnt0_bytes", got_q.size(), 13);
        check("cnt0_cycles", frame_last - frame_first + 1, 520);
        check("cnt0_reads", addr_log.size(), 0);
        for (int i = 0; i < 13 && i < got_q.size(); i++)
            check("cnt0_lit", got_q[i], (i < 9) ? lit34[i] : 8'h00);

        // Two words from the known RAM locations.
        run_dump(17'h00010, 32'd2);
        wait_idle(3000);
        check("cnt2_bytes", got_q.size(), 21);
        for (int i = 0; i < 21 && i < got_q.size(); i++) check("cnt2_lit", got_q[i], lit34[i]);
        check("cnt2_reads", addr_log.size(), 2);

        // Address wrap at the top of the RAM.
        run_dump(17'h1FFFF, 32'd2);
        wait_idle(3000);
        check("wrap_reads", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            check("wrap_addr0", addr_log[0], 32'h1FFFF);
            check("wrap_addr1", addr_log[1], 32'h00000);
        end

        // Second start during the length bytes must be ignored.
        run_dump(17'h00010, 32'd1);
        n = 0;
        while (run_bytes < 10 && n < 2000) begin @(posedge clk); n++; end
        check("restart_reached_length", run_bytes >= 10, 1);
        #1 start = 1'b1; base = 17'h00123; wcount = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(3000);
        check("restart_bytes", got_q.size(), 17);

        // Reset in the middle of a data bit of the first word.
        run_dump(AW'($urandom), 32'd3);
        n = 0;
        while (!(run_bytes == 13 && rx_on && rx_cnt == 3 * DIV + 1) && n < 2000) begin
            @(posedge clk); n++;
        end
        check("reset_point_reached", run_bytes, 13);
        do_reset(1'b1);
        repeat (3) @(posedge clk);
        run_dump(17'h00010, 32'd2);
        wait_idle(3000);
        check("post_reset_bytes", got_q.size(), 21);
        for (int i = 0; i < 21 && i < got_q.size(); i++) check("post_reset_lit", got_q[i], lit34[i]);

        // Random dumps.
        for (int r = 0; r < 6; r++) begin
            run_dump((r % 3 == 0) ? AW'(17'h1FFFF - $urandom_range(0, 2)) : AW'($urandom_range(0, 2**AW - 1)),
                     32'($urandom_range(0, 4)));
            wait_idle(6000);
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        // Real baud divider on the default instance: level runs of the first byte 0x54.
        @(posedge clk); #1 rst2 = 1'b0;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        @(negedge clk);
        n = 0;
        while (tx2 !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        check("div_start_seen", tx2, 0);
        check("div_busy", busy2, 1);
        for (int k = 0; k < 8; k++) begin
            lv = tx2;
            n  = 0;
            while (tx2 === lv && n < 5000) begin n++; @(negedge clk); end
            runs[k] = n;
        end
        for (int k = 0; k < 8; k++) check($sformatf("div_run%0d", k), runs[k], exp_runs[k]);
        #1 rst2 = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
